usr_serial_deserializer: RTL and testbench

USR_SERIAL_DESERIALIZER -- requirements
Module: usr_serial_deserializer

---
 rtl/usr_pkg.sv | 12 +
 rtl/usr_sync_fifo.sv | 63 ++++++
 rtl/usr_serial_deserializer.sv | 101 ++++++++++
 tb/tb_usr_serial_deserializer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared defaults and state type for the serial deserializer slice.
package usr_pkg;

    localparam int unsigned USR_WIDTH = 4;
    localparam int unsigned USR_DEPTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

// File: rtl/usr_sync_fifo.sv
// Single-clock first-word fall-through FIFO. Pointers wrap modulo DEPTH.
module usr_sync_fifo
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = USR_WIDTH,
    parameter int unsigned DEPTH = USR_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    // A push into a full FIFO is only accepted when a pop frees a slot on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since empty masks the read port.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/usr_serial_deserializer.sv
// Assembles framed serial bits into WIDTH-bit words and queues them in a FIFO.
module usr_serial_deserializer
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = USR_WIDTH,
    parameter int unsigned DEPTH = USR_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   serial_in,
    input  logic                   bit_valid,
    input  logic                   sync,
    input  logic                   msb_first,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_n;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt_inc;
    logic             push;
    logic [WIDTH-1:0] word;
    logic             fifo_full;
    logic             fifo_empty;

    // Assembly state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            shreg <= shreg_n;
        end
    end

    // Next-state: sync restarts from an empty register, so partial words vanish.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        push    = 1'b0;
        word    = '0;
        src     = sync ? '0 : shreg;
        cnt_inc = sync ? CW'(1) : cnt + 1'b1;
        shifted = msb_first ? {src[WIDTH-2:0], serial_in}
                            : {serial_in, src[WIDTH-1:1]};
        if (bit_valid && (sync || state == RECV)) begin
            state_n = RECV;
            if (cnt_inc == CW'(WIDTH)) begin
                push    = 1'b1;
                word    = shifted;
                cnt_n   = '0;
                shreg_n = '0;
            end else begin
                cnt_n   = cnt_inc;
                shreg_n = shifted;
            end
        end
    end

    // Sticky drop flag: a completed word found no room and nothing was leaving.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !out_ready) begin
            overflow <= 1'b1;
        end
    end

    usr_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (out_ready),
        .wr_data (word),
        .rd_data (out_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_usr_serial_deserializer.sv
// Directed scoreboard bench for usr_serial_deserializer (WIDTH=4, DEPTH=4).
module tb_usr_serial_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic       bit_valid;
    logic       sync;
    logic       msb_first;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fifo_level;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q [$];

    usr_serial_deserializer #(
        .WIDTH (4),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .sync       (sync),
        .msb_first  (msb_first),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted word must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", out_data);
            end else begin
                check("word_order", int'(out_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_bit(input logic b, input logic s);
        serial_in = b;
        bit_valid = 1'b1;
        sync      = s;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        sync      = 1'b0;
        serial_in = 1'b0;
    endtask

    // bits[3] goes on the wire first.
    task automatic send_seq(input logic [3:0] bits, input logic sync_first);
        for (int i = 3; i >= 0; i--) begin
            send_bit(bits[i], sync_first && (i == 3));
        end
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (fifo_level != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", int'(fifo_level), 0);
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; serial_in = 1'b0; bit_valid = 1'b0; sync = 1'b0;
        msb_first = 1'b1; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_overflow", int'(overflow), 0);

        // MSB-first: 1,0,1,1 -> 1011, visible the cycle after the 4th bit.
        msb_first = 1'b1;
        exp_q.push_back(4'b1011);
        send_seq(4'b1011, 1'b1);
        check("msb_valid", int'(out_valid), 1);
        check("msb_data", int'(out_data), 4'b1011);
        check("msb_level", int'(fifo_level), 1);
        drain();

        // LSB-first: 1,0,1,1 -> 1101.
        msb_first = 1'b0;
        exp_q.push_back(4'b1101);
        send_seq(4'b1011, 1'b1);
        check("lsb_data", int'(out_data), 4'b1101);
        drain();

        // Resync after two bits: partial discarded, then 0,1,1,0 -> 0110.
        msb_first = 1'b1;
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        exp_q.push_back(4'b0110);
        send_seq(4'b0110, 1'b1);
        check("resync_level", int'(fifo_level), 1);
        check("resync_data", int'(out_data), 4'b0110);
        drain();

        // Overflow: five back-to-back words with no consumer, fifth dropped.
        pulse_reset();
        msb_first = 1'b1;
        for (int w = 1; w <= 5; w++) begin
            logic [3:0] v;
            v = 4'(w);
            if (w <= 4) exp_q.push_back(v);
            send_seq(v, w == 1);
        end
        check("ovf_level", int'(fifo_level), 4);
        check("ovf_flag", int'(overflow), 1);
        check("ovf_head", int'(out_data), 1);
        drain();
        check("ovf_sticky", int'(overflow), 1);

        // Full FIFO with simultaneous pop on the completing edge.
        pulse_reset();
        exp_q.push_back(4'h6);
        send_seq(4'h6, 1'b1);
        exp_q.push_back(4'h7);
        send_seq(4'h7, 1'b0);
        exp_q.push_back(4'h8);
        send_seq(4'h8, 1'b0);
        exp_q.push_back(4'hA);
        send_seq(4'hA, 1'b0);
        check("full_level", int'(fifo_level), 4);
        exp_q.push_back(4'h9);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        out_ready = 1'b1;
        send_bit(1'b1, 1'b0);
        out_ready = 1'b0;
        check("pushpop_level", int'(fifo_level), 4);
        check("pushpop_overflow", int'(overflow), 0);
        check("pushpop_head", int'(out_data), 4'h7);
        drain();

        // Reset mid-word wipes everything; unsynced bits then produce nothing.
        out_ready = 1'b0;
        send_seq(4'h3, 1'b1);
        exp_q.delete();
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        serial_in = 1'b1; bit_valid = 1'b1; sync = 1'b1;
        pulse_reset();
        bit_valid = 1'b0; sync = 1'b0;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_data", int'(out_data), 0);
        check("mid_rst_level", int'(fifo_level), 0);
        check("mid_rst_overflow", int'(overflow), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send_bit(1'(i % 2), 1'b0);
        @(posedge clk);
        #1;
        check("nosync_level", int'(fifo_level), 0);
        check("nosync_valid", int'(out_valid), 0);
        out_ready = 1'b0;

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
